// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, parity codes and oversampling constant shared by the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;
  localparam int NONE = 0;
  localparam int ODD = 1;
  localparam int EVEN = 2;
  localparam int OVERSAMPLE = 16;
endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises din as start, DBIT data bits LSB first, optional parity, stop
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY = NONE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);
  localparam logic [5:0] LAST_TICK = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] LAST_STOP = 6'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);
  state_t state, state_n;
  logic [5:0] s, s_n;
  logic [2:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic par, par_n, tx_reg, tx_n, done;
  // state and datapath registers; tx is registered so the line never glitches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      par <= 1'b0;
      tx_reg <= 1'b1;
    end else begin
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
      par <= par_n;
      tx_reg <= tx_n;
    end
  end
  // next-state, counters and the line level that matches the next state
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    par_n = par;
    done = 1'b0;
    case (state)
      IDLE:
        if (tx_start) begin
          b_n = din[DBIT-1:0];
          s_n = '0;
          par_n = 1'b0;
          state_n = START;
        end
      START:
        if (s_tick) begin
          if (s == LAST_TICK) begin
            s_n = '0;
            n_n = '0;
            state_n = DATA;
          end else s_n = s + 6'd1;
        end
      DATA:
        if (s_tick) begin
          if (s == LAST_TICK) begin
            s_n = '0;
            par_n = par ^ b[0];
            b_n = b >> 1;
            if (n == LAST_BIT) state_n = (PARITY != NONE) ? PARITY_BIT : STOP;
            else n_n = n + 3'd1;
          end else s_n = s + 6'd1;
        end
      PARITY_BIT:
        if (s_tick) begin
          if (s == LAST_TICK) begin
            s_n = '0;
            state_n = STOP;
          end else s_n = s + 6'd1;
        end
      STOP:
        if (s_tick) begin
          if (s == LAST_STOP) begin
            state_n = IDLE;
            done = 1'b1;
          end else s_n = s + 6'd1;
        end
      default: state_n = IDLE;
    endcase
    tx_n = (state_n == START) ? 1'b0 :
           (state_n == DATA) ? b_n[0] :
           (state_n == PARITY_BIT) ? ((PARITY == EVEN) ? par_n : ~par_n) : 1'b1;
  end
  assign tx = tx_reg;
  assign tx_busy = (state != IDLE);
  assign tx_done_tick = done & reset_n;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: three parameterisations checked cycle by cycle against a frame-level model
module tb_uart_transmitter;
  logic clk = 1'b0, reset_n = 1'b0, s_tick = 1'b0, tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] tx_d, busy_d, done_d;
  localparam int DB[3] = '{8, 8, 7};
  localparam int SB[3] = '{16, 32, 24};
  localparam int PA[3] = '{0, 2, 1};
  int ncmp = 0, nerr = 0, tmode = 0, per = 10, tcnt = 0;
  bit act[3];
  int k[3], nb[3], tot[3], dcnt[3];
  logic [11:0] fr[3];
  logic [2:0] smp[11];
  bit rx_en = 1'b0, rx_on = 1'b0;
  int rj = 0, nrx = 0;
  logic [7:0] rw;
  logic [7:0] sent[$];

  always #5 clk = ~clk;

  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (.clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(tx_d[0]), .tx_busy(busy_d[0]), .tx_done_tick(done_d[0]));
  uart_transmitter #(.DBIT(8), .SB_TICK(32), .PARITY(2)) u1 (.clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(tx_d[1]), .tx_busy(busy_d[1]), .tx_done_tick(done_d[1]));
  uart_transmitter #(.DBIT(7), .SB_TICK(24), .PARITY(1)) u2 (.clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(tx_d[2]), .tx_busy(busy_d[2]), .tx_done_tick(done_d[2]));

  task automatic cmp(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h required %0h at %0t", nm, i, a, e, $time);
    end
  endtask

  function automatic void build(input int i, input logic [7:0] d);
    logic p;
    p = 1'b0;
    fr[i] = '1;
    fr[i][0] = 1'b0;
    for (int j = 0; j < DB[i]; j++) begin
      fr[i][1+j] = d[j];
      p ^= d[j];
    end
    nb[i] = 1 + DB[i];
    if (PA[i] != 0) begin
      fr[i][nb[i]] = (PA[i] == 2) ? p : ~p;
      nb[i]++;
    end
    tot[i] = 16 * nb[i] + SB[i];
  endfunction

  // tick source: off, every per clocks, or random
  always begin
    @(posedge clk);
    #2;
    tcnt++;
    s_tick = (tmode == 1) ? (tcnt % per == 0) : (tmode == 2) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // frame model: a frame is a list of levels, 16 ticks each, followed by the stop period
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) act[i] = 1'b0;
      else if (act[i]) begin
        if (s_tick) begin
          k[i]++;
          if (k[i] == tot[i]) act[i] = 1'b0;
        end
      end else if (tx_start) begin
        build(i, din);
        act[i] = 1'b1;
        k[i] = 0;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic et;
      int idx;
      idx = k[i] / 16;
      et = act[i] ? ((idx < nb[i]) ? fr[i][idx] : 1'b1) : 1'b1;
      cmp("tx", i, 32'(tx_d[i]), 32'(et));
      cmp("busy", i, 32'(busy_d[i]), 32'(act[i]));
      cmp("done", i, 32'(done_d[i]), 32'(act[i] && s_tick && reset_n && k[i] == tot[i] - 1));
      if (done_d[i] === 1'b1) dcnt[i]++;
    end
  end

  // receiver model on instance 0: centre-samples each bit by tick count
  always @(negedge clk) begin
    if (rx_en && s_tick) begin
      if (!rx_on) begin
        if (tx_d[0] === 1'b0) begin
          rx_on = 1'b1;
          rj = 0;
        end
      end else begin
        rj++;
        if (rj >= 16 && rj < 144 && rj % 16 == 8) rw[rj/16-1] = tx_d[0];
        if (rj == 152) begin
          rx_on = 1'b0;
          cmp("rx_stop", 0, 32'(tx_d[0]), 32'd1);
          if (sent.size() == 0) cmp("rx_extra", 0, 32'(rw), 32'hFFFF_FFFF);
          else cmp("rx_data", nrx, 32'(rw), 32'(sent.pop_front()));
          nrx++;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle;
    int c;
    c = 0;
    while (busy_d != 3'b000 && c < 6000) begin
      step;
      c++;
    end
    if (busy_d != 3'b000) begin
      ncmp++;
      nerr++;
      $display("FAIL idle_wait: busy=%b required 000", busy_d);
    end
  endtask

  // send d, sample every instance at bit centres; mode 1 retriggers with din=FF, mode 2 resets mid-frame
  task automatic frame(input logic [7:0] d, input int mode);
    din = d;
    tx_start = 1'b1;
    step;
    tx_start = 1'b0;
    for (int t = 0; t < 1760; t++) begin
      if (t % 160 == 80) smp[t/160] = tx_d;
      if (mode == 1 && t == 720) begin
        din = 8'hFF;
        tx_start = 1'b1;
      end
      if (mode == 2 && t == 880) begin
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        cmp("rst_mid_tx", 0, 32'(tx_d), 32'h7);
        cmp("rst_mid_busy", 0, 32'(busy_d), 32'h0);
        return;
      end
      step;
      tx_start = 1'b0;
    end
  endtask

  function automatic logic [9:0] seq(input int i);
    logic [9:0] q;
    for (int j = 0; j < 10; j++) q[j] = smp[j][i];
    return q;
  endfunction

  initial begin
    int c, hi;
    int d0[3];
    repeat (3) step;
    cmp("rst_tx", 0, 32'(tx_d), 32'h7);
    cmp("rst_busy", 0, 32'(busy_d), 32'h0);
    reset_n = 1'b1;
    tmode = 1;
    per = 10;
    step;
    frame(8'hA5, 0);
    cmp("seqA5", 0, 32'(seq(0)), 32'b1101001010);
    cmp("evenA5", 1, 32'(smp[9][1]), 32'd0);
    cmp("model_fr", 0, 32'(fr[0][9:0]), 32'b1101001010);
    cmp("model_tot", 0, tot[0], 160);
    cmp("model_tot", 1, tot[1], 192);
    cmp("model_tot", 2, tot[2], 168);
    wait_idle;
    cmp("done_cnt", 0, dcnt[0], 1);
    frame(8'h07, 0);
    cmp("even07", 1, 32'(smp[9][1]), 32'd1);
    cmp("odd07", 2, 32'(smp[8][2]), 32'd0);
    wait_idle;
    d0 = dcnt;
    frame(8'h5A, 1);
    wait_idle;
    repeat (300) step;
    cmp("seq5A_retrig", 0, 32'(seq(0)), 32'b1010110100);
    cmp("retrig_busy", 0, 32'(busy_d), 32'h0);
    cmp("retrig_done", 0, dcnt[0] - d0[0], 1);
    d0 = dcnt;
    frame(8'h3C, 2);
    repeat (300) step;
    cmp("rst_nodone", 0, dcnt[0] - d0[0], 0);
    cmp("rst_nodone", 1, dcnt[1] - d0[1], 0);
    frame(8'hA5, 0);
    cmp("seqA5_after_rst", 0, 32'(seq(0)), 32'b1101001010);
    wait_idle;
    din = 8'h00;
    tx_start = 1'b1;
    step;
    tx_start = 1'b0;
    c = 0;
    hi = 0;
    while (c < 3000) begin
      if (s_tick && tx_d[1] && busy_d[1]) hi++;
      if (done_d[1]) break;
      step;
      c++;
    end
    cmp("stop2_ticks", 1, hi, 32);
    step;
    tx_start = 1'b1;
    step;
    tx_start = 1'b0;
    cmp("b2b_tx", 1, 32'(tx_d[1]), 32'd0);
    cmp("b2b_busy", 1, 32'(busy_d[1]), 32'd1);
    wait_idle;
    per = 1;
    rx_en = 1'b1;
    for (int v = 0; v < 256; v++) begin
      din = 8'(v);
      sent.push_back(8'(v));
      tx_start = 1'b1;
      step;
      tx_start = 1'b0;
      c = 0;
      while (done_d[0] !== 1'b1 && c < 400) begin
        step;
        c++;
      end
      if (c >= 400) begin
        ncmp++;
        nerr++;
        $display("FAIL loop_timeout: frame %0d got no done, required done within 400 clk", v);
      end
      step;
    end
    rx_en = 1'b0;
    cmp("rx_count", 0, nrx, 256);
    wait_idle;
    tmode = 2;
    for (int r = 0; r < 12000; r++) begin
      tx_start = ($urandom_range(0, 5) == 0);
      din = 8'($urandom);
      reset_n = ($urandom_range(0, 3999) != 0);
      step;
    end
    tx_start = 1'b0;
    reset_n = 1'b1;
    wait_idle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one parallel data word onto the UART line `tx`: start bit, DBIT data bits LSB first, optional parity bit, stop period.
- Timed by the shared oversampling tick `s_tick`, 16 ticks per bit, the same tick the UART receiver uses.
- Sits between the system data path and the TX pin; it is the transmit half of the UART pair.

Parameters:
- DBIT, 8: data bits per frame; legal 5..8.
- SB_TICK, 16: `s_tick` count for the stop period; 16, 24 or 32 gives 1, 1.5 or 2 stop bits.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- s_tick  input  1  one-clk-wide oversampling tick, 16 per bit time.
- tx_start  input  1  request to send `din`; sampled only in idle.
- din  input  8  data word; bits [DBIT-1:0] are sent, upper bits ignored.
- tx  output  1  serial line, registered; idles high.
- tx_busy  output  1  high in every state except idle.
- tx_done_tick  output  1  one-clk pulse when the frame ends.

Behaviour:
- Reset: synchronous, active-low (reset_n sampled on rising clk).
  - While reset_n=0 at an edge: state=idle, s=0, n=0, b=0, tx=1, tx_busy=0, tx_done_tick=0.
  - Reset mid-frame aborts the frame: tx=1 after that edge, no tx_done_tick.
- Registers:
  - state (3 bits).
  - s: tick counter, 6 bits, wide enough for SB_TICK-1=31.
  - n: bit counter, 3 bits.
  - b: shift register, DBIT bits.
  - par: running parity, 1 bit.
  - tx_reg: drives `tx` directly, so there are no combinational glitches on the line.
- idle:
  - tx=1.
  - If tx_start=1: b<=din[DBIT-1:0], s<=0, par<=0, go to start.
  - tx_start is ignored in every other state; no queuing.
- start:
  - tx=0.
  - On each s_tick: if s==15, then s<=0, n<=0, go to data; else s<=s+1.
- data:
  - tx=b[0].
  - On s_tick with s==15:
    - s<=0; par<=par^b[0]; b<=b>>1.
    - If n==DBIT-1: go to parity when PARITY!=0, else to stop.
    - Otherwise n<=n+1.
  - Other s_tick: s<=s+1.
- parity (only reached when PARITY!=0):
  - tx = par for even parity, ~par for odd parity.
  - Lasts 16 ticks, then s<=0 and go to stop.
- stop:
  - tx=1.
  - On s_tick with s==SB_TICK-1: go to idle and assert tx_done_tick for that clk only; otherwise s<=s+1.
- Latency:
  - tx falls on the clk edge after tx_start is accepted.
  - Frame length in ticks = 16*(1+DBIT+(PARITY!=0)) + SB_TICK.
- Tick alignment: s_tick can arrive at any phase. The first bit period therefore spans 16 ticks counted from entry, and may be short by up to one tick period of sub-tick phase.
- Back-to-back frames:
  - tx_start is accepted in the clk after tx_done_tick, when state is idle.
  - This gives a minimum of one clk of extra idle between frames.
- Simultaneous events:
  - reset_n=0 overrides everything.
  - tx_start asserted in the same clk as tx_done_tick is ignored, because state is still stop.
- Without s_tick, the state holds indefinitely and tx is stable.
- `din` is captured at acceptance; later changes do not affect the frame in flight.

Decomposition:
- Shared package uart_pkg:
  - state encodings IDLE/START/DATA/PARITY/STOP.
  - PARITY codes NONE/ODD/EVEN.
  - The constant OVERSAMPLE=16, shared with the receiver and the baud-rate tick generator.
- No sub-module: the block is a single FSM with a datapath.
- Verification pairs it with the UART receiver in a loopback bench.

Test Plan:
- Single frame, 8N1, s_tick every 10 clk, din=8'hA5, tx_start pulse:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 160 clk (stop bit also 160 clk).
  - tx_busy high throughout; exactly one tx_done_tick at frame end.
- Even parity, din=8'h07: parity bit=1. Odd parity, din=8'h07: parity bit=0. Frame is 11 bits.
- Two stop bits (SB_TICK=32), din=8'h00:
  - tx high for 32 ticks after the last data bit.
  - A second tx_start the clk after tx_done_tick starts a new start bit immediately.
- tx_start pulsed mid-frame, during the data bit n=3, with din changed to 8'hFF: the frame in flight is unchanged and no second frame is sent.
- reset_n=0 for one clk during data bit n=4: tx=1 and tx_busy=0 on the next edge, no tx_done_tick, and a new tx_start then works normally.
- Loopback into the UART receiver: send 256 values, 8'h00..8'hFF, back-to-back. Every received dout matches the sent value, in order.
